// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one UART serializer among NUM_REQ byte streams.
// An owner keeps the serializer until its last byte has left the line, or until it stalls too long.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   frame_done,
  output logic                   timeout_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_ptr, w_ptr;
  logic [IDX_W-1:0]     r_owner, w_owner;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic                 r_last, w_last;
  logic [NUM_REQ-1:0]   r_grant, w_grant;
  logic [NUM_REQ-1:0]   r_req_ready, w_req_ready;
  logic                 r_tx_start, w_tx_start;
  logic [7:0]           r_tx_data, w_tx_data;
  logic                 r_frame_done, w_frame_done;
  logic                 r_timeout_err, w_timeout_err;

  logic                 w_arb_found;
  logic [IDX_W-1:0]     w_arb_idx;
  int unsigned          w_scan;
  logic [IDX_W-1:0]     w_owner_inc;
  logic [7:0]           w_owner_byte;
  logic                 w_accept;
  logic                 w_expire;

  assign grant       = r_grant;
  assign req_ready   = r_req_ready;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign frame_done  = r_frame_done;
  assign timeout_err = r_timeout_err;

  // First valid requester at or after r_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_scan      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_scan = 32'(r_ptr) + i;
      if (w_scan >= NUM_REQ) w_scan = w_scan - NUM_REQ;
      if (!w_arb_found && req_valid[IDX_W'(w_scan)]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = IDX_W'(w_scan);
      end
    end
  end

  assign w_owner_inc  = (r_owner == LAST_IDX) ? '0 : r_owner + IDX_W'(1);
  assign w_owner_byte = req_data[{r_owner, 3'b000} +: 8];
  assign w_accept     = (r_state == S_LOAD) && req_valid[r_owner] && !tx_busy;
  assign w_expire     = (r_state == S_LOAD) && !w_accept && (r_cnt == CNT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_arb_found) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_accept)      w_state_nxt = S_WAIT_BUSY;
        else if (w_expire) w_state_nxt = S_IDLE;
      end
      S_WAIT_BUSY: if (tx_busy) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) w_state_nxt = r_last ? S_IDLE : S_LOAD;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; pulses default low.
  always_comb begin
    w_ptr         = r_ptr;
    w_owner       = r_owner;
    w_cnt         = r_cnt;
    w_last        = r_last;
    w_grant       = r_grant;
    w_tx_data     = r_tx_data;
    w_req_ready   = '0;
    w_tx_start    = 1'b0;
    w_frame_done  = 1'b0;
    w_timeout_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant = '0;
        if (w_arb_found) begin
          w_owner = w_arb_idx;
          w_grant = ONE_HOT0 << w_arb_idx;
          w_cnt   = '0;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_tx_start  = 1'b1;
          w_tx_data   = w_owner_byte;
          w_req_ready = r_grant;
          w_last      = req_last[r_owner];
          w_cnt       = '0;
        end else if (w_expire) begin
          w_timeout_err = 1'b1;
          w_grant       = '0;
          w_ptr         = w_owner_inc;
          w_cnt         = '0;
        end else if (r_cnt != '1) begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_BUSY: ;
      S_WAIT_DONE: begin
        if (!tx_busy && r_last) begin
          w_frame_done = 1'b1;
          w_grant      = '0;
          w_ptr        = w_owner_inc;
        end
      end
      default: w_grant = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr         <= '0;
      r_owner       <= '0;
      r_cnt         <= '0;
      r_last        <= 1'b0;
      r_grant       <= '0;
      r_req_ready   <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ptr         <= w_ptr;
      r_owner       <= w_owner;
      r_cnt         <= w_cnt;
      r_last        <= w_last;
      r_grant       <= w_grant;
      r_req_ready   <= w_req_ready;
      r_tx_start    <= w_tx_start;
      r_tx_data     <= w_tx_data;
      r_frame_done  <= w_frame_done;
      r_timeout_err <= w_timeout_err;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a busy-for-N serializer drive the DUT, and a
// transaction-level round-robin model predicts grants, bytes, frame_done and timeouts each cycle.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int TO       = 16;
  localparam int BUSY_LEN = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [N-1:0]   grant;
  logic           frame_done;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  // Requester byte queues: bit 8 marks the last byte of a frame.
  logic [8:0] q[N][$];
  logic [N-1:0] en;
  bit           rand_mode;

  int n_chk, n_pass;
  int n_done, n_to;
  int grant_log[$];
  int tx_log[$];
  int exp_q[$];

  // Model state: owner (-1 when idle), rotating pointer and progress of the current byte.
  int   m_owner, m_ptr, m_stall, m_byte_idx;
  bit   m_loading, m_inflight, m_saw_busy, m_last;
  logic [N-1:0] pv;
  logic         pb;
  logic [N-1:0] prev_grant;
  bit           start_prev;
  int           busy_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_log(input string tag, input int g[$], input int e[$]);
    check({tag, "_len"}, g.size(), e.size());
    for (int i = 0; i < e.size(); i++) check(tag, (i < g.size()) ? g[i] : -1, e[i]);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_stall = 0; m_byte_idx = 0;
    m_loading = 0; m_inflight = 0; m_saw_busy = 0; m_last = 0;
  endtask

  task automatic step();
    logic [N-1:0] exp_grant;
    logic         exp_start, exp_done, exp_to;
    logic [7:0]   exp_data;
    @(posedge clk);
    #1;
    exp_start = 0; exp_done = 0; exp_to = 0; exp_data = 8'h00;
    if (rst) begin
      model_reset();
      check("reset_outputs", {grant, req_ready, tx_start, tx_data, frame_done, timeout_err}, 0);
    end else begin
      if (m_owner < 0) begin
        if (pv != 0) begin
          m_owner = pick(pv, m_ptr); m_loading = 1; m_stall = 0; m_byte_idx = 0;
        end
      end else if (m_loading) begin
        if (pv[m_owner] && !pb) begin
          exp_start = 1;
          if (q[m_owner].size() > 0) begin
            exp_data = q[m_owner][0][7:0];
            m_last   = q[m_owner][0][8];
          end
          m_loading = 0; m_inflight = 1; m_saw_busy = 0; m_byte_idx++;
        end else begin
          m_stall++;
          if (m_stall == TO) begin
            exp_to = 1; m_ptr = (m_owner + 1) % N; m_owner = -1; m_loading = 0;
          end
        end
      end else if (m_inflight) begin
        if (!m_saw_busy) begin
          if (pb) m_saw_busy = 1;
        end else if (!pb) begin
          m_inflight = 0;
          if (m_last) begin
            exp_done = 1; m_ptr = (m_owner + 1) % N; m_owner = -1;
          end else begin
            m_loading = 1; m_stall = 0;
          end
        end
      end
      exp_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
      check("grant", grant, exp_grant);
      check("tx_start", tx_start, exp_start);
      check("req_ready", req_ready, exp_start ? exp_grant : '0);
      check("frame_done", frame_done, exp_done);
      check("timeout_err", timeout_err, exp_to);
      if (exp_start) check("tx_data", tx_data, exp_data);
      if (tx_start) tx_log.push_back(int'(tx_data));
      if (grant != 0 && prev_grant == 0) grant_log.push_back(idx_of(grant));
      if (frame_done) n_done++;
      if (timeout_err) n_to++;
    end
    prev_grant = grant;
    // Serializer: busy rises the cycle after tx_start and stays high BUSY_LEN cycles.
    if (start_prev) begin
      tx_busy = 1'b1; busy_cnt = BUSY_LEN;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
    start_prev = tx_start;
    if (rand_mode) for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 7) != 0);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
      req_valid[i]       = en[i] && (q[i].size() > 0);
      req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0][7:0] : 8'h00;
      req_last[i]        = (q[i].size() > 0) ? q[i][0][8] : 1'b0;
    end
    pv = req_valid;
    pb = tx_busy;
  endtask

  task automatic push_frame(input int r, input int len, input int b0);
    for (int k = 0; k < len; k++)
      q[r].push_back({(k == len - 1), (b0 >= 0 && k == 0) ? 8'(b0) : 8'($urandom)});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic run_idle(input int budget);
    int k = 0;
    while ((!all_empty() || m_owner >= 0) && k < budget) begin step(); k++; end
    repeat (2) step();
    check("drain_in_budget", (k < budget), 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    grant_log.delete(); tx_log.delete(); n_done = 0; n_to = 0;
  endtask

  initial begin
    int k;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    en = '1; rand_mode = 0; busy_cnt = 0; start_prev = 0; pv = '0; pb = 1'b0; prev_grant = '0;
    model_reset();
    clear_logs();
    repeat (3) step();
    rst = 1'b0;

    // Single requester, 3-byte frame.
    q[1].push_back({1'b0, 8'h55}); q[1].push_back({1'b0, 8'hAA}); q[1].push_back({1'b1, 8'h0D});
    run_idle(200);
    exp_q = {1}; check_log("t1_grants", grant_log, exp_q);
    exp_q = {8'h55, 8'hAA, 8'h0D}; check_log("t1_bytes", tx_log, exp_q);
    check("t1_frame_done", n_done, 1);

    // Contention right after reset.
    apply_reset(); clear_logs();
    push_frame(0, 1, 8'h10); push_frame(2, 1, 8'h20); push_frame(3, 1, 8'h30);
    run_idle(300);
    exp_q = {0, 2, 3}; check_log("t2_grants", grant_log, exp_q);
    exp_q = {8'h10, 8'h20, 8'h30}; check_log("t2_bytes", tx_log, exp_q);
    check("t2_frame_done", n_done, 3);

    // Round-robin fairness between requesters 0 and 1.
    clear_logs();
    for (int f = 0; f < 3; f++) begin push_frame(0, 1, -1); push_frame(1, 1, -1); end
    run_idle(500);
    exp_q = {0, 1, 0, 1, 0, 1}; check_log("t3_grants", grant_log, exp_q);

    // No interleaving: requester 0 arrives during requester 2's frame.
    clear_logs();
    push_frame(2, 4, 8'hC1);
    k = 0;
    while (tx_log.size() < 1 && k < 100) begin step(); k++; end
    check("t4_first_byte_in_budget", (k < 100), 1);
    push_frame(0, 1, 8'h5A);
    run_idle(400);
    exp_q = {2, 0}; check_log("t4_grants", grant_log, exp_q);
    check("t4_byte_count", tx_log.size(), 5);
    check("t4_req0_last", tx_log.size() == 5 ? tx_log[4] : -1, 8'h5A);

    // Timeout: requester 3 stalls after a non-final byte.
    clear_logs();
    q[3].push_back({1'b0, 8'h41});
    k = 0;
    while (n_to == 0 && k < 100) begin step(); k++; end
    check("t5_timeout_in_budget", (k < 100), 1);
    check("t5_timeout_count", n_to, 1);
    check("t5_grant_cleared", grant, 0);
    push_frame(3, 1, 8'h42); push_frame(0, 1, 8'h43);
    run_idle(300);
    exp_q = {3, 0, 3}; check_log("t5_grants", grant_log, exp_q);
    exp_q = {8'h41, 8'h43, 8'h42}; check_log("t5_bytes", tx_log, exp_q);

    // Asynchronous reset during WAIT_DONE of byte 2 of a 3-byte frame.
    clear_logs();
    push_frame(1, 3, 8'h71);
    k = 0;
    while (!(m_owner == 1 && m_byte_idx == 2 && m_inflight && m_saw_busy) && k < 200) begin
      step(); k++;
    end
    check("t6_reach_wait_done", (k < 200), 1);
    push_frame(2, 1, 8'h72); push_frame(0, 1, 8'h70);
    #2 rst = 1'b1;
    #1 check("t6_async_reset", {grant, req_ready, tx_start, tx_data, frame_done, timeout_err}, 0);
    repeat (2) step();
    rst = 1'b0;
    clear_logs();
    run_idle(400);
    exp_q = {0, 1, 2}; check_log("t6_grants", grant_log, exp_q);

    // Randomized traffic with intermittent valid drops.
    clear_logs();
    rand_mode = 1;
    for (int f = 0; f < 40; f++) begin
      push_frame($urandom_range(0, N - 1), $urandom_range(1, 4), -1);
      repeat ($urandom_range(0, 30)) step();
    end
    k = 0;
    while ((!all_empty() || m_owner >= 0) && k < 20000) begin step(); k++; end
    check("rand_drain_in_budget", (k < 20000), 1);
    rand_mode = 0; en = '1;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-level round-robin arbiter that shares one UART transmitter among up to NUM_REQ byte-stream requesters. A requester that wins keeps the transmitter until it sends its last byte, so frames from different sources never interleave on TXD. The block sits between client logic (command responders, status reporters) and the transmit serializer/baud_gen pair. It sequences each byte through the serializer's start/busy handshake and releases a stalled owner after a timeout.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 65535, idle cycles allowed between bytes of a granted frame before forced release (≥2)
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester byte available; held until matching req_ready
- req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i]
- req_last  input  NUM_REQ  byte currently offered is the final byte of the frame
- req_ready  output  NUM_REQ  one-cycle acknowledge: byte taken
- tx_start  output  1  one-cycle pulse; serializer latches tx_data
- tx_data  output  8  byte to serializer
- tx_busy  input  1  serializer busy; rises the cycle after tx_start, falls after the stop bit
- grant  output  NUM_REQ  one-hot current owner; all zero when idle
- frame_done  output  1  one-cycle pulse when the last byte of a frame has finished on the line
- timeout_err  output  1  one-cycle pulse on forced release

## Operation
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is set, choose the first set bit at or after ptr, searching upward and wrapping modulo NUM_REQ.
  - Register the one-hot grant and go to LOAD.
  - If no req_valid is set, stay in IDLE with grant = 0.
- LOAD:
  - If req_valid[owner] is high and tx_busy is low:
    - register tx_start=1, tx_data=owner byte, req_ready[owner]=1;
    - capture req_last[owner] into last_r;
    - clear the timeout counter and go to WAIT_BUSY.
  - Otherwise increment the timeout counter. The counter saturates and is 16 bits wide.
  - When the counter reaches TIMEOUT−1 with no byte accepted:
    - pulse timeout_err;
    - clear grant;
    - set ptr = owner+1 (mod NUM_REQ);
    - go to IDLE.
- WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: stay until tx_busy=0, then:
  - if last_r is set: pulse frame_done, clear grant, set ptr = owner+1 (mod NUM_REQ), go to IDLE;
  - otherwise return to LOAD with grant unchanged.
- Non-owner requests are ignored while a grant is held. Their req_ready stays 0.
- req_valid changing on a non-owner line has no effect mid-frame.
- req_valid[owner] dropping in LOAD only advances the timeout counter.
- Reset value of ptr is 0, so requester 0 wins the first simultaneous contention.
- Unused or illegal state encodings return to IDLE.

## Timing
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE, ptr=0, grant=0, tx_start=0, tx_data=0x00, req_ready=0, frame_done=0, timeout_err=0, counter=0.
  - A byte already handed to the serializer is not tracked after reset.
- All outputs are registered.
- Request to first byte:
  - req_valid[i] high at edge k → grant valid after edge k.
  - tx_start and req_ready[i] high during cycle k+1→k+2, provided tx_busy is low at edge k+1.
- Byte-to-byte within a frame: LOAD is re-entered one cycle after tx_busy falls. The next tx_start pulses one cycle later, so the gap is 2 clocks after busy deasserts.
- frame_done and the grant clear occur on the same edge. The next arbitration can grant on the following edge.
- tx_start and req_ready are always asserted in the same cycle, for exactly one cycle each.
- At most one req_ready bit is set at a time.
- frame_done and timeout_err are mutually exclusive.

## Test plan
- Single requester, 3-byte frame:
  - stimulus: req 1 sends 0x55, 0xAA, 0x0D (last on 0x0D); model serializer busy for 10 cycles per byte;
  - required: three tx_start pulses carrying those bytes in order, grant=0b0010 throughout, frame_done once after the third busy falls, grant=0 on the next cycle.
- Contention after reset:
  - stimulus: reqs 0, 2 and 3 all valid with 1-byte frames 0x10, 0x20, 0x30;
  - required: service order 0→2→3, tx_data sequence 0x10, 0x20, 0x30, one frame_done per frame.
- Round-robin fairness:
  - stimulus: reqs 0 and 1 continuously offer 1-byte frames for 6 frames;
  - required: grants alternate 0, 1, 0, 1, 0, 1.
- No interleaving:
  - stimulus: req 2 starts a 4-byte frame; req 0 asserts valid after byte 1;
  - required: all 4 bytes of req 2 go out before req 0 is granted; req_ready[0] stays 0 until then.
- Timeout:
  - stimulus: TIMEOUT=16; req 3 sends byte 0x41 (not last), then drops valid;
  - required: timeout_err pulses 16 cycles after LOAD is re-entered, grant clears, next arbitration starts at requester 0.
- Reset mid-frame:
  - stimulus: assert rst during WAIT_DONE of byte 2 of a 3-byte frame;
  - required: all outputs go to reset values immediately (asynchronously); after release, requester 0 has highest priority.
